// File: rtl/sa_tile_processor_db_if.sv
// sa_tile_processor_db_if: beat-in / result-slice-out bus of the systolic tile
interface sa_tile_processor_db_if #(
   parameter int DATA_WIDTH = 8,
   parameter int N = 4,
   parameter int ACC_WIDTH = 32,
   parameter int ID_BITS = 4
);
   logic in_valid, in_ready, in_last, in_signed;
   logic [ID_BITS-1:0] in_row_id, in_col_id;
   logic [N-1:0][DATA_WIDTH-1:0] a_data, b_data;
   logic out_valid, out_ready, out_by_row, out_last;
   logic [N-1:0][ACC_WIDTH-1:0] c_data;
   modport master (
      output in_valid, in_row_id, in_col_id, in_last, in_signed, a_data, b_data, out_ready, out_by_row,
      input in_ready, out_valid, out_last, c_data
   );
   modport slave (
      input in_valid, in_row_id, in_col_id, in_last, in_signed, a_data, b_data, out_ready, out_by_row,
      output in_ready, out_valid, out_last, c_data
   );
endinterface

// File: rtl/sa_tile_processor_db.sv
// sa_tile_processor_db: NxN output-stationary systolic tile with signed/unsigned MACs
// and ping-pong result banks, so one job computes while the previous one streams out.
module sa_tile_processor_db #(
   parameter int DATA_WIDTH = 8,
   parameter int N = 4,
   parameter int ACC_WIDTH = 32,
   parameter int ID_BITS = 4,
   parameter int ROW_ID = 0,
   parameter int COL_ID = 0
) (
   input logic clk,
   input logic reset,
   sa_tile_processor_db_if.slave bus
);
   localparam int CW = $clog2(2 * N + 1);
   localparam int SW = $clog2(N);
   localparam int PW = 2 * DATA_WIDTH + 2;
   localparam logic [SW-1:0] LAST_SLICE = SW'(N - 1);
   typedef enum logic [1:0] {FEED, DRAIN, COMMIT} state_t;
   state_t state, state_nx;
   logic [CW-1:0] cnt;
   logic accept, step, commit, first, mode, wr_ptr, rd_ptr, dir, by_row, fire;
   logic [DATA_WIDTH-1:0] a_src [N], b_src [N], a_in [N], b_in [N];
   logic [DATA_WIDTH-1:0] a_r [N][N], b_r [N][N];
   logic [ACC_WIDTH-1:0] prod [N][N], acc [N][N];
   logic [ACC_WIDTH-1:0] bank [2][N][N];
   logic [1:0] full;
   logic [SW-1:0] slice;

   // One extra operand bit lets a single signed multiplier serve both modes.
   function automatic logic [ACC_WIDTH-1:0] mul(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b, input logic s);
      logic signed [PW-1:0] ax, bx, p;
      ax = PW'($signed({s & a[DATA_WIDTH-1], a}));
      bx = PW'($signed({s & b[DATA_WIDTH-1], b}));
      p = ax * bx;
      return ACC_WIDTH'(p);
   endfunction

   assign bus.in_ready = (state == FEED) && !reset;
   assign accept = bus.in_valid && bus.in_ready && bus.in_row_id == ID_BITS'(ROW_ID) && bus.in_col_id == ID_BITS'(COL_ID);
   assign step = accept || state == DRAIN;
   assign commit = state == COMMIT && !full[wr_ptr];
   assign bus.out_valid = full[rd_ptr];
   assign bus.out_last = full[rd_ptr] && slice == LAST_SLICE;
   assign fire = full[rd_ptr] && bus.out_ready;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         a_src[i] = (state == FEED) ? bus.a_data[i] : '0;
         b_src[i] = (state == FEED) ? bus.b_data[i] : '0;
      end
      state_nx = (state == FEED && accept && bus.in_last) ? DRAIN :
                 (state == DRAIN && cnt == CW'(1)) ? COMMIT :
                 commit ? FEED : state;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= FEED;
         cnt <= '0;
         first <= 1'b1;
         mode <= 1'b0;
      end else begin
         state <= state_nx;
         cnt <= (accept && bus.in_last) ? CW'(2 * N) : (state == DRAIN) ? cnt - 1'b1 : cnt;
         first <= commit ? 1'b1 : accept ? 1'b0 : first;
         mode <= (accept && first) ? bus.in_signed : mode;
      end
   end

   // Row/col i is delayed by i steps so wavefronts meet at PE(i,j) together.
   for (genvar i = 0; i < N; i++) begin : g_skew
      if (i == 0) begin : g_direct
         assign a_in[i] = a_src[i];
         assign b_in[i] = b_src[i];
      end else begin : g_line
         logic [DATA_WIDTH-1:0] al [i], bl [i];
         always_ff @(posedge clk) begin
            if (reset || commit) begin
               for (int k = 0; k < i; k++) begin
                  al[k] <= '0;
                  bl[k] <= '0;
               end
            end else if (step) begin
               al[0] <= a_src[i];
               bl[0] <= b_src[i];
               for (int k = 1; k < i; k++) begin
                  al[k] <= al[k-1];
                  bl[k] <= bl[k-1];
               end
            end
         end
         assign a_in[i] = al[i-1];
         assign b_in[i] = bl[i-1];
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            if (reset || commit) begin
               a_r[i][j] <= '0;
               b_r[i][j] <= '0;
               prod[i][j] <= '0;
               acc[i][j] <= '0;
            end else if (step) begin
               a_r[i][j] <= (j == 0) ? a_in[i] : a_r[i][(j == 0) ? 0 : j - 1];
               b_r[i][j] <= (i == 0) ? b_in[j] : b_r[(i == 0) ? 0 : i - 1][j];
               prod[i][j] <= mul(a_r[i][j], b_r[i][j], mode);
               acc[i][j] <= acc[i][j] + prod[i][j];
            end
         end
      end
   end

   // wr_ptr never equals rd_ptr while both commit and the final beat occur, so the full bits never collide.
   always_ff @(posedge clk) begin
      if (reset) begin
         full <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         slice <= '0;
         dir <= 1'b0;
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
               bank[0][i][j] <= '0;
               bank[1][i][j] <= '0;
            end
         end
      end else begin
         if (commit) begin
            for (int i = 0; i < N; i++) begin
               for (int j = 0; j < N; j++) bank[wr_ptr][i][j] <= acc[i][j];
            end
            full[wr_ptr] <= 1'b1;
            wr_ptr <= ~wr_ptr;
         end
         if (fire) begin
            slice <= (slice == LAST_SLICE) ? '0 : slice + 1'b1;
            dir <= by_row;
            rd_ptr <= (slice == LAST_SLICE) ? ~rd_ptr : rd_ptr;
            if (slice == LAST_SLICE) full[rd_ptr] <= 1'b0;
         end
      end
   end

   always_comb begin
      by_row = (slice == '0) ? bus.out_by_row : dir;
      bus.c_data = '0;
      for (int k = 0; k < N; k++)
         bus.c_data[k] = !full[rd_ptr] ? '0 : by_row ? bank[rd_ptr][slice][k] : bank[rd_ptr][k][slice];
   end
endmodule

// File: tb/tb_sa_tile_processor_db.sv
// tb_sa_tile_processor_db: directed and randomized jobs checked against a plain
// matrix-product model whose results queue up in issue order.
module tb_sa_tile_processor_db;
   localparam int DW = 8, N = 4, AW = 32, IB = 4, RID = 2, CID = 1, MAXK = 8;
   typedef logic [N-1:0][N-1:0][AW-1:0] mat_t;
   logic clk = 0, reset = 1;
   sa_tile_processor_db_if #(.DATA_WIDTH(DW), .N(N), .ACC_WIDTH(AW), .ID_BITS(IB)) bus ();
   sa_tile_processor_db #(.DATA_WIDTH(DW), .N(N), .ACC_WIDTH(AW), .ID_BITS(IB), .ROW_ID(RID), .COL_ID(CID)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );
   always #5 clk = ~clk;

   int n_checks = 0, n_fail = 0, jobs_out = 0, mslice = 0, dir_mode = 0;
   bit mdir, d, rnd_ready;
   mat_t exp_q [$];
   mat_t mcur;
   logic [DW-1:0] ba [MAXK][N], bb [MAXK][N];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
      end
   endtask

   function automatic longint val(input logic [DW-1:0] x, input bit s);
      return s ? longint'($signed(x)) : longint'(x);
   endfunction

   function automatic mat_t model(input int k, input bit s);
      mat_t m;
      longint sum;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            sum = 0;
            for (int t = 0; t < k; t++) sum += val(ba[t][i], s) * val(bb[t][j], s);
            m[i][j] = sum[AW-1:0];
         end
      end
      return m;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      if (rnd_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
      if (dir_mode == 2 || (dir_mode == 1 && mslice != 0)) bus.out_by_row = 1'($urandom_range(0, 1));
   endtask

   task automatic junk_beat(input bit chk);
      int p = $urandom_range(0, 3);
      bus.in_valid = (p != 0);
      bus.in_row_id = (p == 1 || p == 3) ? IB'(RID + $urandom_range(1, 15)) : IB'(RID);
      bus.in_col_id = (p == 2 || p == 3) ? IB'(CID + $urandom_range(1, 15)) : IB'(CID);
      bus.in_last = 1'($urandom_range(0, 1));
      bus.in_signed = 1'($urandom_range(0, 1));
      for (int i = 0; i < N; i++) begin
         bus.a_data[i] = DW'($urandom);
         bus.b_data[i] = DW'($urandom);
      end
      if (chk && p != 0) check("junk_no_stall", 64'(bus.in_ready), 1);
      tick();
      bus.in_valid = 0;
   endtask

   task automatic send_beat(input int t, input bit s, input bit last);
      int w = 0;
      bus.in_valid = 1;
      bus.in_row_id = IB'(RID);
      bus.in_col_id = IB'(CID);
      bus.in_last = last;
      bus.in_signed = (t == 0) ? s : 1'($urandom_range(0, 1));
      for (int i = 0; i < N; i++) begin
         bus.a_data[i] = ba[t][i];
         bus.b_data[i] = bb[t][i];
      end
      while (!bus.in_ready && w < 1000) begin
         tick();
         w++;
      end
      check("in_ready_wait", 64'(w < 1000), 1);
      tick();
      bus.in_valid = 0;
      bus.in_last = 0;
   endtask

   task automatic send_job(input int k, input bit s, input int junk);
      mat_t m = model(k, s);
      for (int t = 0; t < k; t++) begin
         while ($urandom_range(0, 99) < junk) junk_beat(t != 0);
         send_beat(t, s, t == k - 1);
      end
      exp_q.push_back(m);
   endtask

   task automatic load_case1();
      for (int t = 0; t < N; t++) begin
         for (int i = 0; i < N; i++) begin
            ba[t][i] = (i == t) ? DW'(1) : DW'(0);
            bb[t][i] = DW'((i + 1) * (t + 1));
         end
      end
   endtask

   task automatic rand_fill(input int k);
      for (int t = 0; t < k; t++) begin
         for (int i = 0; i < N; i++) begin
            ba[t][i] = ($urandom_range(0, 4) == 0) ? 8'h80 : DW'($urandom);
            bb[t][i] = ($urandom_range(0, 4) == 0) ? 8'hFF : DW'($urandom);
         end
      end
   endtask

   task automatic wait_drain(input string tag);
      int w = 0;
      while (exp_q.size() != 0 && w < 3000) begin
         tick();
         w++;
      end
      check(tag, 64'(exp_q.size()), 0);
   endtask

   task automatic wait_valid();
      int w = 0;
      while (!bus.out_valid && w < 200) begin
         tick();
         w++;
      end
   endtask

   // Expected results leave the queue in order; direction follows the value seen on beat 0.
   always @(negedge clk) begin
      if (reset) begin
         exp_q.delete();
         mslice = 0;
      end else if (bus.out_valid) begin
         if (exp_q.size() == 0) check("spurious_out_valid", 64'(bus.out_valid), 0);
         else begin
            mcur = exp_q[0];
            d = (mslice == 0) ? bus.out_by_row : mdir;
            for (int k = 0; k < N; k++)
               check(d ? "c_row" : "c_col", 64'(bus.c_data[k]), 64'(d ? mcur[mslice][k] : mcur[k][mslice]));
            check("out_last", 64'(bus.out_last), 64'(mslice == N - 1));
            if (bus.out_ready) begin
               if (mslice == 0) mdir = d;
               mslice++;
               if (mslice == N) begin
                  mslice = 0;
                  void'(exp_q.pop_front());
                  jobs_out++;
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int m, j0, w;
      bus.in_valid = 0; bus.in_row_id = '0; bus.in_col_id = '0; bus.in_last = 0; bus.in_signed = 0;
      bus.a_data = '0; bus.b_data = '0; bus.out_ready = 1; bus.out_by_row = 1;
      rnd_ready = 0;
      tick(); tick();
      check("rst_in_ready", 64'(bus.in_ready), 0);
      check("rst_out_valid", 64'(bus.out_valid), 0);
      check("rst_out_last", 64'(bus.out_last), 0);
      check("rst_c_data", 64'(bus.c_data != '0), 0);
      reset = 0;
      tick();
      check("post_rst_in_ready", 64'(bus.in_ready), 1);

      // identity x B, rows out, latency from last beat
      load_case1();
      send_job(N, 0, 0);
      m = 1;
      while (!bus.out_valid && m < 100) begin
         tick();
         m++;
      end
      check("latency", 64'(m), 64'(2 * N + 2));
      wait_drain("drain_case1");

      // single-beat jobs, signed then unsigned
      for (int s = 1; s >= 0; s--) begin
         for (int i = 0; i < N; i++) begin
            ba[0][i] = 8'hFF;
            bb[0][i] = 8'h02;
         end
         send_job(1, 1'(s), 0);
         wait_valid();
         check(s ? "signed_ff_x_02" : "unsigned_ff_x_02", 64'(bus.c_data[N-1]), s ? 64'hFFFF_FFFE : 64'd510);
         wait_drain("drain_case2");
      end

      // column order, direction toggled after the first beat
      bus.out_by_row = 0;
      dir_mode = 1;
      load_case1();
      send_job(N, 0, 0);
      wait_drain("drain_case3");
      dir_mode = 0;
      bus.out_by_row = 1;

      // three jobs with consumer stalled
      bus.out_ready = 0;
      j0 = jobs_out;
      for (int j = 0; j < 3; j++) begin
         rand_fill(N);
         send_job(N, 1'(j == 1), 0);
      end
      repeat (2 * N + 4) tick();
      check("stall_in_ready", 64'(bus.in_ready), 0);
      check("stall_out_valid", 64'(bus.out_valid), 1);
      check("stall_no_output", 64'(jobs_out - j0), 0);
      bus.out_ready = 1;
      wait_drain("drain_case4");
      check("jobs_in_order", 64'(jobs_out - j0), 3);

      // mismatched IDs interleaved
      load_case1();
      send_job(N, 0, 70);
      wait_drain("drain_case5");

      // reset during DRAIN
      load_case1();
      send_job(N, 0, 0);
      repeat (3) tick();
      reset = 1;
      tick();
      check("rst_drain_out_valid", 64'(bus.out_valid), 0);
      check("rst_drain_in_ready", 64'(bus.in_ready), 0);
      reset = 0;
      tick();
      check("rst_drain_in_ready_after", 64'(bus.in_ready), 1);

      // reset during output beat 2
      load_case1();
      send_job(N, 0, 0);
      w = 0;
      while (mslice != 2 && w < 200) begin
         tick();
         w++;
      end
      check("reach_beat2", 64'(mslice), 2);
      reset = 1;
      tick();
      check("rst_stream_out_valid", 64'(bus.out_valid), 0);
      reset = 0;
      tick();
      check("rst_stream_out_last", 64'(bus.out_last), 0);
      load_case1();
      send_job(N, 0, 0);
      wait_drain("drain_case6");

      // randomized jobs with backpressure and random direction
      rnd_ready = 1;
      dir_mode = 2;
      for (int j = 0; j < 25; j++) begin
         int k = $urandom_range(1, MAXK);
         rand_fill(k);
         send_job(k, 1'($urandom_range(0, 1)), 30);
      end
      wait_drain("drain_random");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/sa_tile_processor_db.md
Name: sa_tile_processor_db

Overview:
Next-generation NxN output-stationary systolic tile computing C = A·B over a streamed K dimension.
- Each input beat is one column of A and one row of B, both skewed internally.
- Adds a runtime signed/unsigned mode, a parametrised accumulator width and a ping-pong (double-buffered) output stage, so job n+1 computes while job n streams out.
- Sits in the tile grid behind the row/col ID broadcast bus, like earlier tile generations.

Parameters:
DATA_WIDTH, 8, operand width of A and B elements
N, 4, tile side length (N >= 2)
ACC_WIDTH, 32, accumulator/result width (>= 2*DATA_WIDTH)
ID_BITS, 4, width of row/col destination IDs
ROW_ID, 0, this tile's row ID
COL_ID, 0, this tile's col ID

Ports:
clk  input  1  clock
reset  input  1  reset, synchronous, active-high
in_valid  input  1  input beat valid
in_ready  output  1  tile can accept a beat
in_row_id  input  ID_BITS  B destination row
in_col_id  input  ID_BITS  A destination col
in_last  input  1  final K beat of the job
in_signed  input  1  1 = signed operands (sampled on first beat of a job)
a_data  input  N x DATA_WIDTH  column of A, element i feeds array row i
b_data  input  N x DATA_WIDTH  row of B, element j feeds array col j
out_valid  output  1  c_data holds a valid row/column
out_ready  input  1  consumer accepts beat
out_by_row  input  1  1 = stream rows, 0 = columns (sampled on first beat of each bank)
out_last  output  1  high on the Nth beat of a result
c_data  output  N x ACC_WIDTH  streamed result slice

Behaviour:
- Reset values: in_ready=0 during reset, then 1 in the cycle after; out_valid=0, out_last=0, c_data=0; both banks empty, array/skew regs/accumulators zero, FSM=FEED.
- accept = in_valid && in_ready && in_row_id==ROW_ID && in_col_id==COL_ID.
- Beats with mismatched IDs are ignored; no stall, no state change.
- in_ready = (state==FEED). It does not depend on in_valid.
- FSM:
  - FEED: on accept, shift skew regs and array one step. A non-accept cycle freezes the array (bubble-free).
  - FEED -> DRAIN: on accept with in_last. Drain counter loads 2N.
  - DRAIN: array shifts every cycle with zeros injected. Counter decrements. At 0 -> COMMIT.
  - COMMIT: if a bank is empty, copy all N*N accumulators into it, clear the array and skew regs, then -> FEED. Otherwise hold in COMMIT (in_ready=0, array frozen).
- Bank selection: banks fill alternately. Commit targets the bank after the last one filled. Output always drains the oldest full bank first.
- Arithmetic:
  - Product is 2*DATA_WIDTH, sign- or zero-extended to ACC_WIDTH per the latched mode.
  - Accumulation wraps modulo 2^ACC_WIDTH.
  - Product is registered one cycle before accumulation.
- Latency: last beat accepted at cycle T -> COMMIT at T+2N+1 (banks free) -> out_valid at T+2N+2.
- Output:
  - out_valid is high while the oldest bank holds unsent slices.
  - Beat k (0..N-1) is row k or column k, with element order by index.
  - Slice advances only on out_valid && out_ready.
  - out_last is high on beat N-1.
  - Direction is latched on the first beat of a bank and is stable for that bank.
- Simultaneous events: COMMIT into bank X while the other bank streams its last beat is legal. Both occur in the same cycle.
- A single-beat job (in_last on first beat) is legal.
- Reset mid-job or mid-stream: everything is discarded, returning to the reset state next cycle.

Test Plan:
1. Unsigned, K=4, A=identity, B rows {1,2,3,4}·r (r=1..4), out_by_row=1, out_ready=1 -> 4 beats with row r = {r,2r,3r,4r}; out_last on beat 4; out_valid first at T+2N+2.
2. K=1, a=all 0xFF, b=all 0x02:
   - in_signed=1 -> every c = 0xFFFFFFFE.
   - in_signed=0 -> every c = 510.
3. out_by_row=0 with the case-1 data -> beat k = column k = {k+1, 2(k+1), 3(k+1), 4(k+1)}; toggling out_by_row mid-stream has no effect.
4. out_ready=0 held; three jobs issued -> jobs 1,2 commit, job 3 stalls in COMMIT with in_ready=0. Releasing out_ready streams job 1, job 3 then commits, and jobs emit strictly in order 1,2,3.
5. Interleave beats with wrong ROW_ID/COL_ID between valid beats -> results identical to case 1, and no stall on the mismatched beats.
6. Assert reset during DRAIN and during output beat 2 -> next cycle out_valid=0; a fresh job then yields exact case-1 results (no residue).
